// File: rtl/sub_9bit_signed_stream_if.sv
// Handshake bundle for the streaming signed subtractor: operand pair in, result/overflow out.
interface sub_9bit_signed_stream_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic [15:0]      ovf_count;

  modport master (
    output in_valid, dataa, datab, out_ready,
    input  in_ready, out_valid, result, overflow, ovf_count
  );

  modport slave (
    input  in_valid, dataa, datab, out_ready,
    output in_ready, out_valid, result, overflow, ovf_count
  );
endinterface

// File: rtl/sub_9bit_signed_stream.sv
// Streaming two's-complement subtractor (dataa - datab): operand register, difference register,
// then a show-ahead output FIFO. Input acceptance is credit based so nothing ever stalls internally.
module sub_9bit_signed_stream #(
  parameter int WIDTH      = 9,
  parameter int FIFO_DEPTH = 4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic clock,
  input  logic reset,
  sub_9bit_signed_stream_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
  } entry_t;

  // Stage 1: captured operands
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: computed difference waiting to enter the FIFO
  logic             s2_valid;
  entry_t           s2_entry;

  entry_t           mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [15:0]      ovf_cnt;

  logic             accept;
  logic             pop;
  logic             push;
  logic             out_valid;
  logic [CW:0]      used;
  logic             in_ready;
  logic [WIDTH:0]   diff;
  entry_t           d_entry;

  // Every entry already in the pipeline holds a FIFO slot, so a full FIFO can never be pushed.
  assign used      = {1'b0, count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
  assign in_ready  = used < (CW+1)'(FIFO_DEPTH);
  assign accept    = bus.in_valid & in_ready;
  assign out_valid = count != '0;
  assign pop       = out_valid & bus.out_ready;
  assign push      = s2_valid;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    d_entry          = '0;
    diff             = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
    d_entry.overflow = diff[WIDTH] ^ diff[WIDTH-1];
    d_entry.result   = diff[WIDTH-1:0];
    if (SATURATE && d_entry.overflow) begin
      // Sign of the wide difference tells which rail was crossed.
      d_entry.result = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_cnt  <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && s2_entry.overflow && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  // NOTE: datapath registers and FIFO storage carry no reset; the valid bits and count gate them.
  always_ff @(posedge clock) begin
    if (accept) begin
      s1_a <= bus.dataa;
      s1_b <= bus.datab;
    end
    if (s1_valid) s2_entry <= d_entry;
    if (push)     mem[wr_ptr] <= s2_entry;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = out_valid ? mem[rd_ptr].result : '0;
  assign bus.overflow  = out_valid ? mem[rd_ptr].overflow : 1'b0;
  assign bus.ovf_count = ovf_cnt;
endmodule

// File: tb/tb_sub_9bit_signed_stream.sv
// Directed plus random bench for sub_9bit_signed_stream; a saturating and a wrapping instance share stimulus.
module tb_sub_9bit_signed_stream;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sub_9bit_signed_stream_if #(.WIDTH(9)) s_if ();
  sub_9bit_signed_stream_if #(.WIDTH(9)) w_if ();

  assign w_if.in_valid  = s_if.in_valid;
  assign w_if.dataa     = s_if.dataa;
  assign w_if.datab     = s_if.datab;
  assign w_if.out_ready = s_if.out_ready;

  sub_9bit_signed_stream #(.WIDTH(9), .FIFO_DEPTH(4), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .bus(s_if)
  );
  sub_9bit_signed_stream #(.WIDTH(9), .FIFO_DEPTH(4), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .bus(w_if)
  );

  typedef struct {
    logic [8:0] r;
    logic       o;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  exp_t        q_sat[$];
  exp_t        q_wrap[$];
  logic [15:0] model_ovf = 16'd0;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: true difference, then clamp or take the low 9 bits.
  function automatic exp_t model(logic [8:0] a, logic [8:0] b, bit sat);
    int   d;
    exp_t e;
    d   = int'($signed(a)) - int'($signed(b));
    e.o = (d > 255) || (d < -256);
    if (sat && d > 255)       e.r = 9'h0FF;
    else if (sat && d < -256) e.r = 9'h100;
    else                      e.r = d[8:0];
    return e;
  endfunction

  // Scoreboard: looks at the handshakes that will complete at the coming rising edge.
  always @(negedge clock) begin : scoreboard
    exp_t e;
    if (reset) begin
      q_sat.delete();
      q_wrap.delete();
      model_ovf = 16'd0;
    end else begin
      if (s_if.out_valid && s_if.out_ready) begin
        pops++;
        check("sb_sat_queue_nonempty", 16'(q_sat.size() != 0), 16'd1);
        if (q_sat.size() != 0) begin
          e = q_sat.pop_front();
          check("sb_sat_result", 16'(s_if.result), 16'(e.r));
          check("sb_sat_overflow", 16'(s_if.overflow), 16'(e.o));
        end
      end
      if (w_if.out_valid && w_if.out_ready) begin
        check("sb_wrap_queue_nonempty", 16'(q_wrap.size() != 0), 16'd1);
        if (q_wrap.size() != 0) begin
          e = q_wrap.pop_front();
          check("sb_wrap_result", 16'(w_if.result), 16'(e.r));
          check("sb_wrap_overflow", 16'(w_if.overflow), 16'(e.o));
        end
      end
      if (s_if.in_valid && s_if.in_ready) begin
        e = model(s_if.dataa, s_if.datab, 1'b1);
        q_sat.push_back(e);
        q_wrap.push_back(model(s_if.dataa, s_if.datab, 1'b0));
        if (e.o && model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_one(logic [8:0] a, logic [8:0] b);
    bit ok = 1'b0;
    s_if.dataa    = a;
    s_if.datab    = b;
    s_if.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = s_if.in_ready;
      tick();
    end
    if (!ok) check("send_timeout", 16'(ok), 16'd1);
    s_if.in_valid = 1'b0;
  endtask

  task automatic expect_head(string tag, logic [8:0] r_sat, logic [8:0] r_wrap, logic o);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = s_if.out_valid;
    end
    check({tag, "_valid"}, 16'(seen), 16'd1);
    check({tag, "_sat_result"}, 16'(s_if.result), 16'(r_sat));
    check({tag, "_wrap_result"}, 16'(w_if.result), 16'(r_wrap));
    check({tag, "_sat_overflow"}, 16'(s_if.overflow), 16'(o));
    check({tag, "_wrap_overflow"}, 16'(w_if.overflow), 16'(o));
    tick();
  endtask

  task automatic drain(string tag);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      done = (q_sat.size() == 0) && !s_if.out_valid;
      if (!done) tick();
    end
    check({tag, "_drained"}, 16'(done), 16'd1);
    tick();
  endtask

  initial begin
    int          accepted;
    int          pops0;
    logic [15:0] ovf_before;

    s_if.in_valid  = 1'b0;
    s_if.dataa     = '0;
    s_if.datab     = '0;
    s_if.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_out_valid", 16'(s_if.out_valid), 16'd0);
    check("rst_result", 16'(s_if.result), 16'd0);
    check("rst_overflow", 16'(s_if.overflow), 16'd0);
    check("rst_in_ready", 16'(s_if.in_ready), 16'd1);
    check("rst_ovf_count", s_if.ovf_count, 16'd0);
    tick();

    // Basic 1 - (-1) with latency check
    s_if.out_ready = 1'b1;
    s_if.dataa     = 9'h001;
    s_if.datab     = 9'h1FF;
    s_if.in_valid  = 1'b1;
    @(negedge clock);
    check("basic_in_ready", 16'(s_if.in_ready), 16'd1);
    tick();
    s_if.in_valid = 1'b0;
    @(negedge clock);
    check("basic_lat_k", 16'(s_if.out_valid), 16'd0);
    tick();
    @(negedge clock);
    check("basic_lat_k1", 16'(s_if.out_valid), 16'd0);
    tick();
    expect_head("basic", 9'h002, 9'h002, 1'b0);

    // Mixed sign 37 - 66
    send_one(9'h025, 9'h042);
    expect_head("mixed", 9'h1E3, 9'h1E3, 1'b0);

    // Positive then negative overflow
    send_one(9'h0FF, 9'h1FF);
    send_one(9'h100, 9'h001);
    expect_head("ovf_pos", 9'h0FF, 9'h100, 1'b1);
    expect_head("ovf_neg", 9'h100, 9'h0FF, 1'b1);
    drain("ovf");
    check("ovf_count_sat", s_if.ovf_count, 16'd2);
    check("ovf_count_wrap", w_if.ovf_count, 16'd2);

    // Backpressure: only the credit count of pairs may enter
    s_if.out_ready = 1'b0;
    s_if.in_valid  = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      s_if.dataa = 9'($urandom);
      s_if.datab = 9'($urandom);
      @(negedge clock);
      if (s_if.in_ready) accepted++;
      tick();
    end
    s_if.in_valid = 1'b0;
    @(negedge clock);
    check("bp_accepted", 16'(accepted), 16'd4);
    check("bp_in_ready_low", 16'(s_if.in_ready), 16'd0);
    tick();
    pops0 = pops;
    s_if.out_ready = 1'b1;
    drain("bp");
    check("bp_popped", 16'(pops - pops0), 16'd4);

    // Full-rate random streaming
    s_if.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_if.dataa = 9'($urandom);
      s_if.datab = 9'($urandom);
      @(negedge clock);
      check("stream_in_ready", 16'(s_if.in_ready), 16'd1);
      tick();
    end
    s_if.in_valid = 1'b0;
    drain("stream");
    check("stream_ovf_count_sat", s_if.ovf_count, model_ovf);
    check("stream_ovf_count_wrap", w_if.ovf_count, model_ovf);

    // Reset with three entries queued
    s_if.out_ready = 1'b0;
    send_one(9'h0FF, 9'h100);
    send_one(9'h011, 9'h022);
    send_one(9'h033, 9'h044);
    tick();
    tick();
    @(negedge clock);
    ovf_before = s_if.ovf_count;
    check("pre_rst_queued", 16'(s_if.out_valid), 16'd1);
    check("pre_rst_ovf_nonzero", 16'(ovf_before != 16'd0), 16'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_out_valid", 16'(s_if.out_valid), 16'd0);
    check("midrst_in_ready", 16'(s_if.in_ready), 16'd1);
    check("midrst_ovf_count", s_if.ovf_count, 16'd0);
    check("midrst_result", 16'(s_if.result), 16'd0);
    tick();
    s_if.out_ready = 1'b1;
    send_one(9'h00A, 9'h003);
    expect_head("post_rst_first", 9'h007, 9'h007, 1'b0);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
